mdu_unit: RTL

- Multiply/divide unit in the EX stage, parallel to the ALU; takes the same forwarded operands A/B and the decoded MD operation.
- Owns the HI/LO architectural registers.
- Runs multi-cycle MULT/MULTU/DIV/DIVU, executes MTHI/MTLO, and supplies HI/LO to the EX result mux for MFHI/MFLO.
- busy stalls IF/ID/EX in the hazard unit while an operation is in flight.

---
 rtl/mdu_unit_pkg.sv | 80 ++++++++
 rtl/mdu_unit_if.sv | 38 +++
 rtl/mdu_div32.sv | 59 +++++
 rtl/mdu_unit.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mdu_unit_pkg.sv
// mdu_unit_pkg -- shared definitions for the multiply/divide unit.
//
// Holds the mdOp code points, the FSM state encoding, the default busy
// cycle counts and small decode helpers used by the unit and its interface.
//
// Optional feature macro: MDU_MADD_EN -- when defined, the MADD/MADDU/
// MSUB/MSUBU codes decode as multiply-accumulate operations; otherwise
// they decode as no-ops.

package mdu_unit_pkg;

    localparam int DATA_W          = 32;
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic [3:0] {
        MD_NONE  = 4'b0000,
        MD_MULT  = 4'b0001,
        MD_MULTU = 4'b0010,
        MD_DIV   = 4'b0011,
        MD_DIVU  = 4'b0100,
        MD_MTHI  = 4'b0101,
        MD_MTLO  = 4'b0110,
        MD_MADD  = 4'b0111,
        MD_MADDU = 4'b1000,
        MD_MSUB  = 4'b1001,
        MD_MSUBU = 4'b1010
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_e;

    // Ops that occupy the multiplier for MULT_CYCLES.
    function automatic logic is_mul_op(input logic [3:0] op);
        case (op)
            MD_MULT, MD_MULTU: return 1'b1;
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    // Ops that occupy the divider for DIV_CYCLES.
    function automatic logic is_div_op(input logic [3:0] op);
        case (op)
            MD_DIV, MD_DIVU: return 1'b1;
            default:         return 1'b0;
        endcase
    endfunction

    // Ops whose operands are interpreted as two's complement.
    function automatic logic is_signed_op(input logic [3:0] op);
        case (op)
            MD_MULT, MD_DIV, MD_MADD, MD_MSUB: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

`ifdef MDU_MADD_EN
    // Ops that fold the product into the existing {HI,LO}.
    function automatic logic is_acc_op(input logic [3:0] op);
        case (op)
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

    function automatic logic is_sub_op(input logic [3:0] op);
        case (op)
            MD_MSUB, MD_MSUBU: return 1'b1;
            default:           return 1'b0;
        endcase
    endfunction
`endif

endpackage

// File: rtl/mdu_unit_if.sv
// mdu_unit_if -- EX-stage bundle between the pipeline and the MDU.
//
// Signals:
//   A, B      forwarded rs / rt operands
//   mdOp      decoded multiply/divide operation
//   start     one-cycle strobe, mdOp valid this cycle
//   flush     kills any in-flight op
//   readHi    selects HI (1) or LO (0) onto mdResult
//   busy      op in flight (stalls IF/ID/EX)
//   HI, LO    architectural HI/LO registers
//   mdResult  readHi ? HI : LO
// Modports: master = pipeline side, slave = MDU side.

interface mdu_unit_if;
    import mdu_unit_pkg::*;

    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [3:0]        mdOp;
    logic              start;
    logic              flush;
    logic              readHi;
    logic              busy;
    logic [DATA_W-1:0] HI;
    logic [DATA_W-1:0] LO;
    logic [DATA_W-1:0] mdResult;

    modport master (
        output A, B, mdOp, start, flush, readHi,
        input  busy, HI, LO, mdResult
    );

    modport slave (
        input  A, B, mdOp, start, flush, readHi,
        output busy, HI, LO, mdResult
    );

endinterface

// File: rtl/mdu_div32.sv
// mdu_div32 -- combinational 32-bit signed/unsigned divide datapath.
//
// Ports:
//   dividend, divisor  (in)  operands
//   is_signed          (in)  1 = two's complement divide
//   quotient           (out) truncated toward zero
//   remainder          (out) carries the sign of the dividend
//   div_zero           (out) divisor is zero; quotient/remainder are 0 and
//                            the caller must not commit them
// The signed overflow case 0x80000000 / -1 yields quotient 0x80000000 and
// remainder 0.

module mdu_div32
    import mdu_unit_pkg::*;
(
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    input  logic              is_signed,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              div_zero
);

    logic              neg_a;
    logic              neg_b;
    logic              ovf;
    logic [DATA_W-1:0] mag_a;
    logic [DATA_W-1:0] mag_b;
    logic [DATA_W-1:0] q_mag;
    logic [DATA_W-1:0] r_mag;

    always_comb begin
        div_zero = (divisor == '0);
        ovf      = is_signed
                   && (dividend == {1'b1, {(DATA_W-1){1'b0}}})
                   && (divisor == {DATA_W{1'b1}});
        neg_a    = is_signed & dividend[DATA_W-1];
        neg_b    = is_signed & divisor[DATA_W-1];
        // Divide on magnitudes, then restore signs; -0x80000000 is still
        // 0x80000000 as an unsigned magnitude, which is exactly what we need.
        mag_a    = neg_a ? (~dividend + 1'b1) : dividend;
        mag_b    = neg_b ? (~divisor + 1'b1) : divisor;
        q_mag    = '0;
        r_mag    = '0;
        if (!div_zero) begin
            q_mag = mag_a / mag_b;
            r_mag = mag_a % mag_b;
        end

        quotient  = (neg_a ^ neg_b) ? (~q_mag + 1'b1) : q_mag;
        remainder = neg_a ? (~r_mag + 1'b1) : r_mag;

        if (ovf) begin
            quotient  = {1'b1, {(DATA_W-1){1'b0}}};
            remainder = '0;
        end
    end

endmodule

// File: rtl/mdu_unit.sv
// mdu_unit -- EX-stage multiply/divide unit owning the HI/LO registers.
//
// Ports:
//   clk    (in)  rising-edge clock
//   rst_n  (in)  asynchronous active-low reset
//   bus    (mdu_unit_if.slave) operands, mdOp/start/flush/readHi in;
//          busy, HI, LO and mdResult out
// Parameters:
//   MULT_CYCLES  busy cycles for multiply-class ops (>= 1)
//   DIV_CYCLES   busy cycles for divide ops (>= 1)
// Optional feature macro: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU
// (multiply-accumulate into {HI,LO}); without it those codes are no-ops.
//
// Operands and op are latched on the start edge; the result is computed
// from the latched copies and committed on the edge ending the last busy
// cycle, so a read in the cycle busy falls already sees the new value.

module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)
(
    input  logic       clk,
    input  logic       rst_n,
    mdu_unit_if.slave  bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    md_state_e           state;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    lim;
    logic                busy_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [3:0]          op_q;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;

    logic                signed_op;
    logic [2*DATA_W-1:0] a_ext;
    logic [2*DATA_W-1:0] b_ext;
    logic [2*DATA_W-1:0] product;
    logic [2*DATA_W-1:0] mul_result;
    logic [DATA_W-1:0]   div_q;
    logic [DATA_W-1:0]   div_r;
    logic                div_zero;
    logic                last_cycle;

    // Multiply datapath: sign/zero-extend to 64 bits so one truncated
    // 64x64 product serves both signed and unsigned forms.
    always_comb begin
        signed_op  = is_signed_op(op_q);
        a_ext      = signed_op ? {{DATA_W{a_q[DATA_W-1]}}, a_q} : {{DATA_W{1'b0}}, a_q};
        b_ext      = signed_op ? {{DATA_W{b_q[DATA_W-1]}}, b_q} : {{DATA_W{1'b0}}, b_q};
        product    = a_ext * b_ext;
        mul_result = product;
`ifdef MDU_MADD_EN
        // Accumulate against {HI,LO} as it stands at completion.
        if (is_acc_op(op_q)) begin
            mul_result = is_sub_op(op_q) ? ({hi_q, lo_q} - product)
                                         : ({hi_q, lo_q} + product);
        end
`endif
    end

    mdu_div32 u_div (
        .dividend  (a_q),
        .divisor   (b_q),
        .is_signed (signed_op),
        .quotient  (div_q),
        .remainder (div_r),
        .div_zero  (div_zero)
    );

    always_comb begin
        lim        = (state == ST_MUL) ? CNT_W'(MULT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
        last_cycle = (cnt == lim);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // A flush in the same cycle cancels the start outright.
                    if (bus.start && !bus.flush) begin
                        if (is_mul_op(bus.mdOp)) begin
                            state  <= ST_MUL;
                            cnt    <= '0;
                            busy_q <= 1'b1;
                            a_q    <= bus.A;
                            b_q    <= bus.B;
                            op_q   <= bus.mdOp;
                        end else if (is_div_op(bus.mdOp)) begin
                            state  <= ST_DIV;
                            cnt    <= '0;
                            busy_q <= 1'b1;
                            a_q    <= bus.A;
                            b_q    <= bus.B;
                            op_q   <= bus.mdOp;
                        end else if (bus.mdOp == MD_MTHI) begin
                            hi_q <= bus.A;
                        end else if (bus.mdOp == MD_MTLO) begin
                            lo_q <= bus.A;
                        end
                    end
                end

                // start is deliberately not looked at while busy.
                ST_MUL: begin
                    if (bus.flush) begin
                        state  <= ST_IDLE;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                    end else if (last_cycle) begin
                        state  <= ST_IDLE;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                        hi_q   <= mul_result[2*DATA_W-1:DATA_W];
                        lo_q   <= mul_result[DATA_W-1:0];
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ST_DIV: begin
                    if (bus.flush) begin
                        state  <= ST_IDLE;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                    end else if (last_cycle) begin
                        state  <= ST_IDLE;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                        // Divide by zero still spends the full busy time
                        // but leaves HI/LO untouched.
                        if (!div_zero) begin
                            hi_q <= div_r;
                            lo_q <= div_q;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state  <= ST_IDLE;
                    cnt    <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.HI       = hi_q;
    assign bus.LO       = lo_q;
    assign bus.mdResult = bus.readHi ? hi_q : lo_q;

endmodule
